output_layer_seq: RTL and testbench
===================================

Name: output_layer_seq

Overview:
Output-layer sequencer that sits directly downstream of the 32x8 hidden-unit RAM. On start it reads all hidden activations once per output neuron and fetches the matching weights from an external weight ROM. It multiply-accumulates them, then emits one saturated 8-bit result per output neuron. At the end it reports the argmax class index.

Parameters:
N_HID, 32, hidden units per output; must match the hidden RAM depth; hidden address width 5
N_OUT, 10, number of output neurons
FRAC_BITS, 4, arithmetic right shift applied to the accumulator before saturation
ACC_W, 24, accumulator width; at least 16 + clog2(N_HID) + 1
W_ADDR_W, 9, weight ROM address width; at least clog2(N_OUT*N_HID)

Ports:
clk  in  1  system clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin; ignored while busy
hid_addr  out  5  hidden RAM read address
hid_q  in  8  hidden RAM data, signed; valid the cycle after hid_addr is presented (RAM registers its address)
w_addr  out  W_ADDR_W  weight ROM address = out_idx*N_HID + hid_idx
w_q  in  8  weight data, signed; same one-cycle latency as hid_q
busy  out  1  high from the cycle after start is accepted until done
out_valid  out  1  one-cycle pulse per output neuron
out_idx  out  4  index of the neuron being emitted; valid with out_valid
out_data  out  8  signed saturated neuron result; valid with out_valid
done  out  1  one-cycle pulse after the last neuron is emitted
class_idx  out  4  argmax of out_data over the pass; updated with done, held until the next done

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator, counters, max register and class_idx cleared. The reset takes effect immediately, including mid-pass. No partial done or out_valid is produced after reset.
- States: IDLE, RUN, EMIT, DONE.
- IDLE:
  - start=1 clears out_idx, cnt, acc and max_val (max_val set to -128), then enters RUN.
  - busy rises in the next cycle.
- RUN, counter cnt runs 0..N_HID:
  - While cnt < N_HID: hid_addr = cnt[4:0] and w_addr = out_idx*N_HID + cnt.
  - While cnt > 0: acc += sext(hid_q) * sext(w_q). This is a signed 8x8 to 16-bit product, sign-extended to ACC_W.
  - At cnt == N_HID the final product is accumulated and the state moves to EMIT.
  - Addresses are don't-care but are held at their last value when cnt == N_HID.
- EMIT, one cycle:
  - out_valid=1 and out_idx = the current neuron.
  - out_data = sat8(acc >>> FRAC_BITS), where sat8 clamps to [-128, 127].
  - If out_data > max_val (strict), then max_val <= out_data and arg <= out_idx. Ties keep the lower index.
  - acc is cleared.
  - If out_idx == N_OUT-1, go to DONE. Otherwise increment out_idx, set cnt=0 and return to RUN.
- DONE, one cycle: done=1, class_idx <= arg, busy=0, then IDLE.
- Latency: N_HID+2 cycles per neuron, plus 1 for DONE. With defaults, the first out_valid comes 34 cycles after the start cycle and done comes 341 cycles after it.
- A start asserted in DONE or while busy is dropped; no queuing.
- hid_q and w_q are consumed exactly one cycle after their address. The block never stalls.
- The accumulator never wraps for legal widths. Saturation is applied only at EMIT.

Decomposition:
- Shared package: state enum (IDLE/RUN/EMIT/DONE), the 8-bit signed data type shared with the MAC and hidden RAM, and the sat8 function.
- One natural sub-module: snn_mac_acc. It holds a signed 8x8 multiply plus an ACC_W accumulator with clear and enable. It is reusable by the hidden-layer stage.
- The sequencer FSM, address generation and argmax stay in output_layer_seq.

Test Plan:
- Reset mid-RUN (rst_n low at cnt=10 of neuron 3) -> all outputs 0 immediately; no out_valid or done until a new start; the next pass gives correct results.
- All hidden=1, all weights=1, FRAC_BITS=4 -> acc=32 per neuron; out_data=2 for all 10 neurons; class_idx=0 (tie rule); done exactly 341 cycles after start.
- Hidden=127 and weights=127 everywhere -> acc=516128; out_data saturates to 127. Hidden=127 with weights=-128 -> out_data=-128.
- Neuron k weights all = k, hidden all = 16, FRAC_BITS=4 -> out_data = 32*k (k=0..3 gives 0, 32, 64, 96; k>=4 gives 127). class_idx=4, the first neuron to saturate.
- Address check with a scoreboard model RAM/ROM using the one-cycle registered-address model -> w_addr sequence 0..31 for neuron 0, then 32..63 for neuron 1, and so on; hid_addr repeats 0..31 per neuron; products pair hidden[i] with weight[out_idx*32+i].
- start pulsed again at cycles 5 and 200 of a pass -> ignored; exactly 10 out_valid and 1 done; a start one cycle after done begins a new pass.

Source files
------------

// File: rtl/output_layer_seq_pkg.sv
// Shared types for the output-layer sequencer and its MAC: FSM states,
// the signed 8-bit activation/weight type and the 8-bit saturation helper.
package output_layer_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_t;

    typedef logic signed [7:0] data_t;

    // Clamp a wide signed value into [-128, 127].
    function automatic data_t sat8(input logic signed [63:0] x);
        data_t r;
        if (x > 64'sd127)
            r = data_t'(8'sd127);
        else if (x < -64'sd128)
            r = data_t'(-8'sd128);
        else
            r = data_t'(x[7:0]);
        return r;
    endfunction

endpackage

// File: rtl/output_layer_seq_mac.sv
// Signed 8x8 multiply feeding a wide accumulator with synchronous clear/enable.
// Reused by the hidden-layer stage.
module snn_mac_acc
    import output_layer_seq_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  data_t                   a,
    input  data_t                   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [15:0] prod;

    assign prod = 16'(a) * 16'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/output_layer_seq.sv
// Output-layer sequencer: streams hidden activations and weights through a MAC
// once per output neuron, emits saturated results and reports the argmax class.
module output_layer_seq
    import output_layer_seq_pkg::*;
#(
    parameter int N_HID     = 32,
    parameter int N_OUT     = 10,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = 24,
    parameter int W_ADDR_W  = 9,
    parameter int HID_AW    = $clog2(N_HID)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [HID_AW-1:0]   hid_addr,
    input  data_t               hid_q,
    output logic [W_ADDR_W-1:0] w_addr,
    input  data_t               w_q,
    output logic                busy,
    output logic                out_valid,
    output logic [3:0]          out_idx,
    output data_t               out_data,
    output logic                done,
    output logic [3:0]          class_idx
);

    localparam int CNT_W = $clog2(N_HID + 1);

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    data_t                    max_val;
    logic [3:0]               arg;
    logic                     mac_clr, mac_en;
    logic signed [ACC_W-1:0]  acc;
    data_t                    emit_val;
    logic                     last_cnt, last_out;

    assign last_cnt = (cnt == CNT_W'(N_HID));
    assign last_out = (out_idx == 4'(N_OUT - 1));

    // Data returns one cycle after its address, so the product for address
    // cnt-1 is accumulated while cnt is presented; cnt == N_HID drains the last.
    assign mac_clr = (state == IDLE && start) || (state == EMIT);
    assign mac_en  = (state == RUN) && (cnt != '0);

    snn_mac_acc #(.ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (hid_q),
        .b     (w_q),
        .acc   (acc)
    );

    assign emit_val = sat8(64'(acc >>> FRAC_BITS));

    always_comb begin
        hid_addr = '0;
        w_addr   = '0;
        if (state == RUN) begin
            hid_addr = last_cnt ? HID_AW'(N_HID - 1) : cnt[HID_AW-1:0];
            w_addr   = W_ADDR_W'(out_idx) * W_ADDR_W'(N_HID) + W_ADDR_W'(hid_addr);
        end
    end

    assign busy      = (state == RUN) || (state == EMIT);
    assign out_valid = (state == EMIT);
    assign out_data  = (state == EMIT) ? emit_val : data_t'(0);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)    state_nxt = RUN;
            RUN:  if (last_cnt) state_nxt = EMIT;
            EMIT: state_nxt = last_out ? DONE : RUN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            out_idx   <= '0;
            max_val   <= '0;
            arg       <= '0;
            class_idx <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt     <= '0;
                    out_idx <= '0;
                    max_val <= data_t'(-8'sd128);
                    arg     <= '0;
                end
                RUN: cnt <= cnt + 1'b1;
                EMIT: begin
                    // Strict compare keeps the lower index on ties.
                    if (emit_val > max_val) begin
                        max_val <= emit_val;
                        arg     <= out_idx;
                    end
                    if (!last_out) begin
                        out_idx <= out_idx + 1'b1;
                        cnt     <= '0;
                    end
                end
                DONE: class_idx <= arg;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer_seq.sv
// Self-checking bench for output_layer_seq: fixed-pattern table, randomized
// passes against an arithmetic reference model, reset and start-ignore corners.
module tb_output_layer_seq;

    logic              clk, rst_n, start;
    logic [4:0]        hid_addr;
    logic signed [7:0] hid_q, w_q;
    logic [8:0]        w_addr;
    logic              busy, out_valid, done;
    logic [3:0]        out_idx, class_idx;
    logic signed [7:0] out_data;

    output_layer_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .hid_addr(hid_addr), .hid_q(hid_q),
        .w_addr(w_addr), .w_q(w_q),
        .busy(busy), .out_valid(out_valid), .out_idx(out_idx),
        .out_data(out_data), .done(done), .class_idx(class_idx)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    byte hid_mem [32];
    byte w_mem   [512];

    // Registered-address RAM/ROM models.
    always @(posedge clk) begin
        hid_q <= hid_mem[hid_addr];
        w_q   <= w_mem[w_addr];
    end

    int n_chk = 0;
    int n_fail = 0;
    int exp_d [10];
    int exp_cls;

    typedef struct packed {
        int             hv;
        int             wmode;   // 0: every weight = wv, 1: neuron k weight = k*wv
        int             wv;
        logic [9:0][7:0] ed;
        int             cls;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic fill_const(input int hv, input int wmode, input int wv);
        for (int i = 0; i < 32; i++) hid_mem[i] = byte'(hv);
        for (int a = 0; a < 512; a++) w_mem[a] = 8'sd0;
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < 32; i++)
                w_mem[k*32+i] = byte'(wmode ? k*wv : wv);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++) hid_mem[i] = byte'($urandom);
        for (int a = 0; a < 512; a++) w_mem[a] = byte'($urandom);
    endtask

    // Reference: dot product, floor divide by 16, clamp, first strict maximum.
    task automatic model();
        int s, best;
        best = -128;
        exp_cls = 0;
        for (int k = 0; k < 10; k++) begin
            s = 0;
            for (int i = 0; i < 32; i++) s += int'(hid_mem[i]) * int'(w_mem[k*32+i]);
            s = s >>> 4;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            exp_d[k] = s;
            if (s > best) begin best = s; exp_cls = k; end
        end
    endtask

    task automatic run_pass(input bit extra, input string tag);
        int t, nv, done_t, first_v, addr_err, n, j;
        bit seen;
        nv = 0; done_t = -1; first_v = -1; addr_err = 0; seen = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        t = 1;
        chk({tag, " busy_rise"}, int'(busy), 1);
        while (!seen && t < 2000) begin
            if (out_valid) begin
                if (first_v < 0) first_v = t;
                if (nv < 10) begin
                    chk({tag, " out_idx"}, int'(out_idx), nv);
                    chk({tag, " out_data"}, int'(out_data), exp_d[nv]);
                end
                nv++;
            end
            n = (t - 1) / 34;
            j = (t - 1) % 34;
            if (n < 10 && j < 32 && (int'(hid_addr) != j || int'(w_addr) != n*32 + j))
                addr_err++;
            if (done) begin
                seen = 1;
                done_t = t;
                chk({tag, " busy_at_done"}, int'(busy), 0);
            end else begin
                start = extra && (t == 5 || t == 200);
                @(posedge clk); #1;
                start = 0;
                t++;
            end
        end
        chk({tag, " first_valid_cycle"}, first_v, 34);
        chk({tag, " valid_count"}, nv, 10);
        chk({tag, " done_cycle"}, done_t, 341);
        chk({tag, " addr_errors"}, addr_err, 0);
        @(posedge clk); #1;
        chk({tag, " class_idx"}, int'(class_idx), exp_cls);
        chk({tag, " done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int cnt_v, cnt_d;

        tbl[0].hv = 1;   tbl[0].wmode = 0; tbl[0].wv = 1;
        tbl[0].ed = {10{8'd2}};   tbl[0].cls = 0;
        tbl[1].hv = 127; tbl[1].wmode = 0; tbl[1].wv = 127;
        tbl[1].ed = {10{8'd127}}; tbl[1].cls = 0;
        tbl[2].hv = 127; tbl[2].wmode = 0; tbl[2].wv = -128;
        tbl[2].ed = {10{8'h80}};  tbl[2].cls = 0;
        tbl[3].hv = 16;  tbl[3].wmode = 1; tbl[3].wv = 1;
        tbl[3].ed = {{6{8'd127}}, 8'd96, 8'd64, 8'd32, 8'd0}; tbl[3].cls = 4;

        start = 0;
        rst_n = 0;
        fill_const(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset done", int'(done), 0);
        chk("reset class_idx", int'(class_idx), 0);
        chk("reset out_data", int'(out_data), 0);
        rst_n = 1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            fill_const(tbl[v].hv, tbl[v].wmode, tbl[v].wv);
            for (int k = 0; k < 10; k++) exp_d[k] = int'($signed(tbl[v].ed[k]));
            exp_cls = tbl[v].cls;
            run_pass(0, $sformatf("table%0d", v));
        end

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            model();
            run_pass(r == 1, $sformatf("rand%0d", r));
        end

        // Reset asserted at cnt=10 of neuron 3.
        fill_rand();
        model();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (112) @(posedge clk);
        #1;
        chk("midrun busy_before_reset", int'(busy), 1);
        rst_n = 0;
        #1;
        chk("midrun_rst busy", int'(busy), 0);
        chk("midrun_rst out_idx", int'(out_idx), 0);
        chk("midrun_rst hid_addr", int'(hid_addr), 0);
        chk("midrun_rst w_addr", int'(w_addr), 0);
        chk("midrun_rst class_idx", int'(class_idx), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        cnt_v = 0; cnt_d = 0;
        repeat (400) begin
            @(posedge clk); #1;
            if (out_valid) cnt_v++;
            if (done) cnt_d++;
        end
        chk("post_rst stray out_valid", cnt_v, 0);
        chk("post_rst stray done", cnt_d, 0);
        run_pass(0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
